fix_session_mgr: RTL and testbench
==================================

FIX_SESSION_MGR -- requirements
Module: fix_session_mgr

Interface
REQ-001 Parameter NUM_HOSTS, default 4, number of independent host sessions (2..16).
REQ-002 Parameter HOST_W, default $clog2(NUM_HOSTS), host index width.
REQ-003 Parameter TIMEOUT_CYC, default 16, cycles allowed in WAIT before the attempt expires (1..255).
REQ-004 Parameter MAX_RETRY, default 3, re-issues allowed after the first attempt before failure (0..7).
REQ-005 One clock, clk; reset is asynchronous and active-high, rst.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  async active-high reset.
REQ-008 connect_i  in  1  app connect request, one-cycle pulse.
REQ-009 connect_to_host_i  in  HOST_W  host index for connect_i.
REQ-010 disconnect_i  in  1  app disconnect request, one-cycle pulse.
REQ-011 disconnect_host_i  in  HOST_W  host index for disconnect_i.
REQ-012 connected_i  in  1  TOE connection-established pulse.
REQ-013 connected_host_addr_i  in  HOST_W  host index for connected_i.
REQ-014 req_ready_i  in  1  downstream FIFO accepts the current request.
REQ-015 connect_req_o  out  1  connect request valid.
REQ-016 connect_addr_o  out  HOST_W  host index for connect_req_o.
REQ-017 disconnect_o  out  1  disconnect request valid.
REQ-018 disconnect_host_num_o  out  HOST_W  host index for disconnect_o.
REQ-019 session_up_o  out  NUM_HOSTS  bit h high while host h is UP.
REQ-020 conn_fail_o  out  1  one-cycle pulse: host exhausted retries.
REQ-021 fail_host_o  out  HOST_W  host index for conn_fail_o; valid only with it.
REQ-022 unexpected_o  out  1  one-cycle pulse: connected_i for a host not in WAIT.

Function
REQ-023 Each host SHALL have an independent FSM: IDLE, REQ, WAIT, UP, DISC.
REQ-024 IDLE->REQ on connect_i for that host; retry count cleared.
REQ-025 REQ->WAIT when that host's connect request is accepted (connect_req_o & req_ready_i); timer cleared.
REQ-026 WAIT->UP on connected_i with matching host.
REQ-027 WAIT with timer reaching TIMEOUT_CYC: if retry count < MAX_RETRY, go to REQ and increment retry count; else go to IDLE and pulse conn_fail_o with fail_host_o = host in the following cycle.
REQ-028 UP, REQ or WAIT -> DISC on disconnect_i for that host; DISC->IDLE when its disconnect request is accepted.
REQ-029 A host in REQ whose connect request is already presented SHALL stay in REQ until acceptance, then move to DISC instead of WAIT.
REQ-030 connect_i to a non-IDLE host and disconnect_i to an IDLE host SHALL be ignored.
REQ-031 Host indices >= NUM_HOSTS on any input SHALL be ignored.
REQ-032 Priority: disconnect_i beats connect_i, and connected_i beats timeout, when they hit the same host in the same cycle.
REQ-033 At most one of connect_req_o and disconnect_o SHALL be high per cycle, from a single registered output slot.
REQ-034 When the slot is empty, a round-robin arbiter SHALL load the first host in REQ or DISC at or after pointer rr; rr then becomes granted host + 1, mod NUM_HOSTS.
REQ-035 A loaded request SHALL hold valid and index stable until req_ready_i; the slot SHALL reload at the earliest on the cycle after acceptance.
REQ-036 Latency: connect_i sampled on edge N with the slot empty SHALL make connect_req_o high after edge N+1.
REQ-037 The WAIT timer SHALL saturate, and the retry counter SHALL be 3 bits wide.
REQ-038 connected_i for a host in REQ, DISC, UP or IDLE SHALL cause no state change and SHALL pulse unexpected_o in the next cycle.

Reset
REQ-039 While rst is high: all hosts IDLE; timers, retry counts, rr and the output slot cleared; all outputs 0. Reset mid-request SHALL drop the presented request.

Verification
REQ-040 connect_i, host 0; req_ready_i=1; connected_i, host 0, two cycles later -> connect_req_o after edge N+1 with connect_addr_o=0; session_up_o=4'b0001.
REQ-041 connect_i, host 2; never connected; TIMEOUT_CYC=16, MAX_RETRY=3 -> four connect_req_o for host 2, then conn_fail_o with fail_host_o=2; host 2 IDLE.
REQ-042 Hosts 1 and 3 both in REQ, rr=0, req_ready_i=1 -> host 1 granted, then host 3.
REQ-043 req_ready_i=0 for 5 cycles with host 0 presented -> connect_req_o and connect_addr_o stable all 5 cycles.
REQ-044 connect_i and disconnect_i to host 1 in the same cycle -> host 1 stays IDLE, no output.
REQ-045 Host 0 UP, disconnect_i host 0 -> disconnect_o with disconnect_host_num_o=0; session_up_o[0]=0; then IDLE after acceptance.

Source files
------------

// File: rtl/fix_session_mgr_if.sv
// rtl/fix_session_mgr_if.sv - application/TOE handshake bundle for the FIX session manager
interface fix_session_mgr_if #(
    parameter int NUM_HOSTS = 4,
    parameter int HOST_W    = $clog2(NUM_HOSTS)
);
    logic                 connect_i;
    logic [HOST_W-1:0]    connect_to_host_i;
    logic                 disconnect_i;
    logic [HOST_W-1:0]    disconnect_host_i;
    logic                 connected_i;
    logic [HOST_W-1:0]    connected_host_addr_i;
    logic                 req_ready_i;
    logic                 connect_req_o;
    logic [HOST_W-1:0]    connect_addr_o;
    logic                 disconnect_o;
    logic [HOST_W-1:0]    disconnect_host_num_o;
    logic [NUM_HOSTS-1:0] session_up_o;
    logic                 conn_fail_o;
    logic [HOST_W-1:0]    fail_host_o;
    logic                 unexpected_o;

    modport master (
        output connect_i, connect_to_host_i, disconnect_i, disconnect_host_i,
               connected_i, connected_host_addr_i, req_ready_i,
        input  connect_req_o, connect_addr_o, disconnect_o, disconnect_host_num_o,
               session_up_o, conn_fail_o, fail_host_o, unexpected_o
    );

    modport slave (
        input  connect_i, connect_to_host_i, disconnect_i, disconnect_host_i,
               connected_i, connected_host_addr_i, req_ready_i,
        output connect_req_o, connect_addr_o, disconnect_o, disconnect_host_num_o,
               session_up_o, conn_fail_o, fail_host_o, unexpected_o
    );
endinterface

// File: rtl/fix_session_mgr.sv
// rtl/fix_session_mgr.sv - per-host connect/retry/disconnect FSMs sharing one round-robin request slot
module fix_session_mgr #(
    parameter int NUM_HOSTS   = 4,
    parameter int HOST_W      = $clog2(NUM_HOSTS),
    parameter int TIMEOUT_CYC = 16,
    parameter int MAX_RETRY   = 3
) (
    input  logic             clk,
    input  logic             rst,
    fix_session_mgr_if.slave bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_UP, ST_DISC} host_state_t;

    host_state_t          state_q [NUM_HOSTS];
    host_state_t          state_d [NUM_HOSTS];
    logic [7:0]           timer_q [NUM_HOSTS];
    logic [7:0]           timer_d [NUM_HOSTS];
    logic [2:0]           retry_q [NUM_HOSTS];
    logic [2:0]           retry_d [NUM_HOSTS];
    logic [NUM_HOSTS-1:0] pend_q, pend_d;
    logic [NUM_HOSTS-1:0] conn_vec, disc_vec, cted_vec, held_vec, up_vec;

    logic              slot_valid, slot_disc;
    logic [HOST_W-1:0] slot_host, rr_q, grant, arb_host;
    logic              grant_found, accept, load;
    int                arb_idx;

    logic              fail_q, fail_d, unexp_q, unexp_d;
    logic [HOST_W-1:0] fail_host_q, fail_host_d;

    assign accept = slot_valid & bus.req_ready_i;
    assign load   = ~slot_valid & grant_found;

    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        arb_idx     = 0;
        arb_host    = '0;
        for (int i = 0; i < NUM_HOSTS; i++) begin
            arb_idx = int'(rr_q) + i;
            if (arb_idx >= NUM_HOSTS) arb_idx = arb_idx - NUM_HOSTS;
            arb_host = HOST_W'(arb_idx);
            if (!grant_found && (state_q[arb_host] == ST_REQ || state_q[arb_host] == ST_DISC)) begin
                grant_found = 1'b1;
                grant       = arb_host;
            end
        end
    end

    // Matching against h < NUM_HOSTS also discards out-of-range indices.
    // A connect being loaded this cycle counts as already presented.
    always_comb begin
        conn_vec = '0;
        disc_vec = '0;
        cted_vec = '0;
        held_vec = '0;
        up_vec   = '0;
        for (int h = 0; h < NUM_HOSTS; h++) begin
            conn_vec[h] = bus.connect_i    && (bus.connect_to_host_i == HOST_W'(h));
            disc_vec[h] = bus.disconnect_i && (bus.disconnect_host_i == HOST_W'(h));
            cted_vec[h] = bus.connected_i  && (bus.connected_host_addr_i == HOST_W'(h));
            held_vec[h] = (slot_valid && !slot_disc && slot_host == HOST_W'(h)) ||
                          (load && grant == HOST_W'(h));
            up_vec[h]   = (state_q[h] == ST_UP);
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        retry_d     = retry_q;
        pend_d      = pend_q;
        fail_d      = 1'b0;
        fail_host_d = '0;
        unexp_d     = 1'b0;
        for (int h = 0; h < NUM_HOSTS; h++) begin
            case (state_q[h])
                ST_IDLE: begin
                    if (conn_vec[h] && !disc_vec[h]) begin
                        state_d[h] = ST_REQ;
                        retry_d[h] = '0;
                        pend_d[h]  = 1'b0;
                    end
                end
                ST_REQ: begin
                    if (held_vec[h] && accept) begin
                        pend_d[h] = 1'b0;
                        if (pend_q[h] || disc_vec[h]) begin
                            state_d[h] = ST_DISC;
                        end else begin
                            state_d[h] = ST_WAIT;
                            timer_d[h] = '0;
                        end
                    end else if (disc_vec[h]) begin
                        if (held_vec[h]) pend_d[h] = 1'b1;
                        else             state_d[h] = ST_DISC;
                    end
                end
                ST_WAIT: begin
                    if (disc_vec[h]) begin
                        state_d[h] = ST_DISC;
                    end else if (cted_vec[h]) begin
                        state_d[h] = ST_UP;
                    end else if (timer_q[h] >= 8'(TIMEOUT_CYC)) begin
                        if (retry_q[h] < 3'(MAX_RETRY)) begin
                            state_d[h] = ST_REQ;
                            retry_d[h] = retry_q[h] + 3'd1;
                        end else begin
                            state_d[h] = ST_IDLE;
                            // Simultaneous failures report the lowest host only.
                            if (!fail_d) begin
                                fail_d      = 1'b1;
                                fail_host_d = HOST_W'(h);
                            end
                        end
                    end else if (timer_q[h] != 8'hFF) begin
                        timer_d[h] = timer_q[h] + 8'd1;
                    end
                end
                ST_UP: begin
                    if (disc_vec[h]) state_d[h] = ST_DISC;
                end
                ST_DISC: begin
                    if (accept && slot_disc && slot_host == HOST_W'(h)) state_d[h] = ST_IDLE;
                end
                default: state_d[h] = ST_IDLE;
            endcase
            if (cted_vec[h] && state_q[h] != ST_WAIT) unexp_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int h = 0; h < NUM_HOSTS; h++) begin
                state_q[h] <= ST_IDLE;
                timer_q[h] <= '0;
                retry_q[h] <= '0;
            end
            pend_q      <= '0;
            slot_valid  <= 1'b0;
            slot_disc   <= 1'b0;
            slot_host   <= '0;
            rr_q        <= '0;
            fail_q      <= 1'b0;
            fail_host_q <= '0;
            unexp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            pend_q      <= pend_d;
            fail_q      <= fail_d;
            fail_host_q <= fail_host_d;
            unexp_q     <= unexp_d;
            if (accept) begin
                slot_valid <= 1'b0;
            end else if (load) begin
                slot_valid <= 1'b1;
                slot_host  <= grant;
                slot_disc  <= (state_q[grant] == ST_DISC);
                rr_q       <= (grant == HOST_W'(NUM_HOSTS - 1)) ? '0 : grant + HOST_W'(1);
            end
        end
    end

    assign bus.connect_req_o         = slot_valid & ~slot_disc;
    assign bus.connect_addr_o        = slot_host;
    assign bus.disconnect_o          = slot_valid & slot_disc;
    assign bus.disconnect_host_num_o = slot_host;
    assign bus.session_up_o          = up_vec;
    assign bus.conn_fail_o           = fail_q;
    assign bus.fail_host_o           = fail_host_q;
    assign bus.unexpected_o          = unexp_q;
endmodule

// File: tb/tb_fix_session_mgr.sv
// tb/tb_fix_session_mgr.sv - directed self-checking bench for fix_session_mgr
module tb_fix_session_mgr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fix_session_mgr_if #(.NUM_HOSTS(4)) bus ();

    fix_session_mgr #(
        .NUM_HOSTS(4), .TIMEOUT_CYC(16), .MAX_RETRY(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.connect_i             = 1'b0;
        bus.connect_to_host_i     = '0;
        bus.disconnect_i          = 1'b0;
        bus.disconnect_host_i     = '0;
        bus.connected_i           = 1'b0;
        bus.connected_host_addr_i = '0;
        bus.req_ready_i           = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic pulse_connect(input logic [1:0] h);
        bus.connect_i = 1'b1; bus.connect_to_host_i = h;
        step();
        bus.connect_i = 1'b0;
    endtask

    task automatic pulse_disconnect(input logic [1:0] h);
        bus.disconnect_i = 1'b1; bus.disconnect_host_i = h;
        step();
        bus.disconnect_i = 1'b0;
    endtask

    task automatic pulse_connected(input logic [1:0] h);
        bus.connected_i = 1'b1; bus.connected_host_addr_i = h;
        step();
        bus.connected_i = 1'b0;
    endtask

    task automatic bring_up(input logic [1:0] h);
        bus.req_ready_i = 1'b1;
        pulse_connect(h);
        step();
        step();
        pulse_connected(h);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        n_tests++;
        if ({bus.connect_req_o, bus.disconnect_o} !== 2'b00) begin
            n_fail++; $display("FAIL reset_req: got %b expected 00", {bus.connect_req_o, bus.disconnect_o});
        end
        n_tests++;
        if (bus.session_up_o !== 4'b0000) begin
            n_fail++; $display("FAIL reset_up: got %b expected 0000", bus.session_up_o);
        end
        n_tests++;
        if ({bus.conn_fail_o, bus.unexpected_o} !== 2'b00) begin
            n_fail++; $display("FAIL reset_pulses: got %b expected 00", {bus.conn_fail_o, bus.unexpected_o});
        end
        bus.connect_i = 1'b1;
        step();
        step();
        bus.connect_i = 1'b0;
        n_tests++;
        if (bus.connect_req_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_ignores_connect: got %b expected 0", bus.connect_req_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_connect();
        do_reset();
        bus.req_ready_i = 1'b1;
        pulse_connect(2'd0);
        n_tests++;
        if (bus.connect_req_o !== 1'b0) begin
            n_fail++; $display("FAIL connect_latency_n: got %b expected 0", bus.connect_req_o);
        end
        step();
        n_tests++;
        if ({bus.connect_req_o, bus.connect_addr_o} !== 3'b1_00) begin
            n_fail++; $display("FAIL connect_latency_n1: got %b expected 100", {bus.connect_req_o, bus.connect_addr_o});
        end
        step();
        pulse_connected(2'd0);
        n_tests++;
        if (bus.session_up_o !== 4'b0001) begin
            n_fail++; $display("FAIL connect_up: got %b expected 0001", bus.session_up_o);
        end
        n_tests++;
        if (bus.unexpected_o !== 1'b0) begin
            n_fail++; $display("FAIL connect_no_unexpected: got %b expected 0", bus.unexpected_o);
        end
    endtask

    task automatic test_timeout();
        int req_cnt = 0;
        int fail_cnt = 0;
        logic [1:0] fhost = 2'd0;
        do_reset();
        bus.req_ready_i = 1'b1;
        pulse_connect(2'd2);
        for (int c = 0; c < 150; c++) begin
            step();
            if (bus.connect_req_o && bus.connect_addr_o == 2'd2) req_cnt++;
            if (bus.conn_fail_o) begin
                fail_cnt++;
                fhost = bus.fail_host_o;
            end
        end
        n_tests++;
        if (req_cnt !== 4) begin
            n_fail++; $display("FAIL timeout_attempts: got %0d expected 4", req_cnt);
        end
        n_tests++;
        if (fail_cnt !== 1) begin
            n_fail++; $display("FAIL timeout_fail_pulses: got %0d expected 1", fail_cnt);
        end
        n_tests++;
        if (fhost !== 2'd2) begin
            n_fail++; $display("FAIL timeout_fail_host: got %0d expected 2", fhost);
        end
        pulse_connected(2'd2);
        n_tests++;
        if ({bus.unexpected_o, bus.session_up_o} !== 5'b1_0000) begin
            n_fail++; $display("FAIL timeout_idle: got %b expected 10000", {bus.unexpected_o, bus.session_up_o});
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] g [4];
        int ng = 0;
        do_reset();
        pulse_connect(2'd0);
        step();
        pulse_connect(2'd3);
        pulse_connect(2'd1);
        bus.req_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (bus.connect_req_o) begin
                if (ng < 4) g[ng] = bus.connect_addr_o;
                ng++;
            end
        end
        n_tests++;
        if (ng !== 2) begin
            n_fail++; $display("FAIL rr_count: got %0d expected 2", ng);
        end else begin
            n_tests++;
            if ({g[0], g[1]} !== {2'd1, 2'd3}) begin
                n_fail++; $display("FAIL rr_order: got %0d,%0d expected 1,3", g[0], g[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        pulse_connect(2'd0);
        step();
        pulse_connect(2'd2);
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if ({bus.connect_req_o, bus.connect_addr_o} !== 3'b1_00) begin
                n_fail++; $display("FAIL hold_cycle%0d: got %b expected 100", c, {bus.connect_req_o, bus.connect_addr_o});
            end
            step();
        end
        bus.req_ready_i = 1'b1;
        step();
        n_tests++;
        if (bus.connect_req_o !== 1'b0) begin
            n_fail++; $display("FAIL reload_gap: got %b expected 0", bus.connect_req_o);
        end
        step();
        n_tests++;
        if ({bus.connect_req_o, bus.connect_addr_o} !== 3'b1_10) begin
            n_fail++; $display("FAIL reload_next: got %b expected 110", {bus.connect_req_o, bus.connect_addr_o});
        end
    endtask

    task automatic test_conn_disc_same();
        int out_cnt = 0;
        do_reset();
        bus.req_ready_i  = 1'b1;
        bus.connect_i    = 1'b1; bus.connect_to_host_i = 2'd1;
        bus.disconnect_i = 1'b1; bus.disconnect_host_i = 2'd1;
        step();
        bus.connect_i    = 1'b0;
        bus.disconnect_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (bus.connect_req_o || bus.disconnect_o) out_cnt++;
            step();
        end
        n_tests++;
        if (out_cnt !== 0) begin
            n_fail++; $display("FAIL same_cycle_outputs: got %0d expected 0", out_cnt);
        end
        pulse_connected(2'd1);
        n_tests++;
        if (bus.unexpected_o !== 1'b1) begin
            n_fail++; $display("FAIL same_cycle_idle: got %b expected 1", bus.unexpected_o);
        end
        step();
        n_tests++;
        if (bus.unexpected_o !== 1'b0) begin
            n_fail++; $display("FAIL unexpected_one_cycle: got %b expected 0", bus.unexpected_o);
        end
    endtask

    task automatic test_disconnect();
        do_reset();
        bring_up(2'd0);
        pulse_disconnect(2'd0);
        n_tests++;
        if ({bus.session_up_o[0], bus.disconnect_o} !== 2'b00) begin
            n_fail++; $display("FAIL disc_down: got %b expected 00", {bus.session_up_o[0], bus.disconnect_o});
        end
        step();
        n_tests++;
        if ({bus.disconnect_o, bus.disconnect_host_num_o, bus.connect_req_o} !== 4'b1_00_0) begin
            n_fail++; $display("FAIL disc_req: got %b expected 1000", {bus.disconnect_o, bus.disconnect_host_num_o, bus.connect_req_o});
        end
        step();
        n_tests++;
        if (bus.disconnect_o !== 1'b0) begin
            n_fail++; $display("FAIL disc_accepted: got %b expected 0", bus.disconnect_o);
        end
        pulse_connect(2'd0);
        step();
        n_tests++;
        if ({bus.connect_req_o, bus.connect_addr_o} !== 3'b1_00) begin
            n_fail++; $display("FAIL disc_idle: got %b expected 100", {bus.connect_req_o, bus.connect_addr_o});
        end
    endtask

    task automatic test_disc_while_presented();
        do_reset();
        pulse_connect(2'd0);
        step();
        pulse_disconnect(2'd0);
        n_tests++;
        if ({bus.connect_req_o, bus.connect_addr_o} !== 3'b1_00) begin
            n_fail++; $display("FAIL pend_hold: got %b expected 100", {bus.connect_req_o, bus.connect_addr_o});
        end
        bus.req_ready_i = 1'b1;
        step();
        n_tests++;
        if ({bus.connect_req_o, bus.disconnect_o} !== 2'b00) begin
            n_fail++; $display("FAIL pend_gap: got %b expected 00", {bus.connect_req_o, bus.disconnect_o});
        end
        step();
        n_tests++;
        if ({bus.disconnect_o, bus.disconnect_host_num_o} !== 3'b1_00) begin
            n_fail++; $display("FAIL pend_disc: got %b expected 100", {bus.disconnect_o, bus.disconnect_host_num_o});
        end
        step();
        n_tests++;
        if ({bus.connect_req_o, bus.disconnect_o, bus.session_up_o} !== 6'b0) begin
            n_fail++; $display("FAIL pend_done: got %b expected 000000", {bus.connect_req_o, bus.disconnect_o, bus.session_up_o});
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        pulse_connect(2'd1);
        step();
        n_tests++;
        if (bus.connect_req_o !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: got %b expected 1", bus.connect_req_o);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (bus.connect_req_o !== 1'b0) begin
            n_fail++; $display("FAIL midrst_async: got %b expected 0", bus.connect_req_o);
        end
        step();
        rst = 1'b0;
        bus.req_ready_i = 1'b1;
        step();
        step();
        n_tests++;
        if (bus.connect_req_o !== 1'b0) begin
            n_fail++; $display("FAIL midrst_dropped: got %b expected 0", bus.connect_req_o);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_connect();
        test_timeout();
        test_round_robin();
        test_backpressure();
        test_conn_disc_same();
        test_disconnect();
        test_disc_while_presented();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
